// File: rtl/instr_readback_tx.sv
// instr_readback_tx: dumps every instruction RAM word as six UART 8N1 bytes
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   start    request a full dump, sampled only in IDLE
//   rd_addr  instruction RAM read address (current word index)
//   rd_data  combinational RAM read data {opcode[3:0], sel[1:0], op1h, op1l, op2h, op2l}
//   tx       registered UART serial out, idles high
//   busy     dump in progress
//   done     one-cycle pulse when the dump completes
module instr_readback_tx #(
    parameter int NUMBER_OF_INSTRUCTIONS = 4,
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [11:0] rd_addr,
    input  logic [37:0] rd_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    typedef enum logic [2:0] {IDLE, LOAD, START_BIT, DATA_BIT, STOP_BIT} state_t;
    state_t        r_state, w_nxt;
    logic [BW-1:0] r_baud, w_baud;
    logic [2:0]    r_byte, w_byte, r_bit, w_bit;
    logic [11:0]   r_addr, w_addr;
    logic [47:0]   r_word;
    logic          r_tx, r_busy, r_done, w_tx, w_done, w_last;
    logic [5:0]    w_idx;
    assign w_last  = r_baud == BW'(CLKS_PER_BIT - 1);
    assign rd_addr = r_addr;
    assign tx      = r_tx;
    assign busy    = r_busy;
    assign done    = r_done;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_byte  <= '0;
            r_bit   <= '0;
            r_addr  <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_baud  <= w_baud;
            r_byte  <= w_byte;
            r_bit   <= w_bit;
            r_addr  <= w_addr;
            r_tx    <= w_tx;
            r_busy  <= w_nxt != IDLE;
            r_done  <= w_done;
        end
        if (r_state == LOAD)
            r_word <= {4'b0, rd_data[37:34], 6'b0, rd_data[33:32], rd_data[31:0]};
    end
    always_comb begin
        w_nxt  = r_state;
        w_baud = w_last ? '0 : r_baud + 1'b1;
        w_byte = r_byte;
        w_bit  = r_bit;
        w_addr = r_addr;
        case (r_state)
            IDLE: begin
                w_baud = '0;
                w_byte = '0;
                w_bit  = '0;
                w_nxt  = start ? LOAD : IDLE;
            end
            LOAD: begin
                w_baud = '0;
                w_byte = '0;
                w_nxt  = START_BIT;
            end
            START_BIT: if (w_last) begin
                w_nxt = DATA_BIT;
                w_bit = '0;
            end
            DATA_BIT: if (w_last) begin
                if (r_bit == 3'd7) w_nxt = STOP_BIT;
                else w_bit = r_bit + 1'b1;
            end
            STOP_BIT: if (w_last) begin
                if (r_byte < 3'd5) begin
                    w_byte = r_byte + 1'b1;
                    w_nxt  = START_BIT;
                end else if (r_addr < 12'(NUMBER_OF_INSTRUCTIONS - 1)) begin
                    w_addr = r_addr + 1'b1;
                    w_nxt  = LOAD;
                end else begin
                    w_addr = '0;
                    w_nxt  = IDLE;
                end
            end
            default: w_nxt = IDLE;
        endcase
    end
    // tx is registered from the next state so the line changes together with the state
    assign w_idx = {3'd5 - w_byte, w_bit};
    always_comb begin
        w_tx   = w_nxt == START_BIT ? 1'b0 : w_nxt == DATA_BIT ? r_word[w_idx] : 1'b1;
        w_done = r_state == STOP_BIT && w_nxt == IDLE;
    end
endmodule
